// File: rtl/wb_stage_pipelined_pkg.sv
// Shared types for the writeback stage: result-select codes, load funct3 codes
// and the stage occupancy states.
package wb_stage_pipelined_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    WB_EMPTY   = 2'b00,
    WB_FULL    = 2'b01,
    WB_WAIT_LD = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_stage_pipelined_load_align.sv
// Load lane extraction: picks the byte/half/word lane (aligned down to the access
// size) out of the raw memory word and sign- or zero-extends it to XLEN.
module wb_stage_pipelined_load_align
  import wb_stage_pipelined_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3_i,
  input  logic [OFF_W-1:0] addr_lo_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  data_o
);

  logic [OFF_W+2:0] byteIdx;
  logic [OFF_W+2:0] halfIdx;
  logic [7:0]       byteLane;
  logic [15:0]      halfLane;
  logic [XLEN-1:0]  wordSext;
  logic [XLEN-1:0]  wordZext;

  assign byteIdx  = {addr_lo_i, 3'b000};
  assign halfIdx  = {addr_lo_i[OFF_W-1:1], 4'b0000};
  assign byteLane = rdata_i[byteIdx +: 8];
  assign halfLane = rdata_i[halfIdx +: 16];

  // Word lanes only exist on RV64; on RV32 a word access is already full width.
  generate
    if (XLEN > 32) begin : gWide
      logic [OFF_W+2:0] wordIdx;
      logic [31:0]      wordLane;
      assign wordIdx  = {addr_lo_i[OFF_W-1:2], 5'b00000};
      assign wordLane = rdata_i[wordIdx +: 32];
      assign wordSext = {{(XLEN-32){wordLane[31]}}, wordLane};
      assign wordZext = {{(XLEN-32){1'b0}}, wordLane};
    end else begin : gNarrow
      assign wordSext = rdata_i;
      assign wordZext = rdata_i;
    end
  endgenerate

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byteLane[7]}}, byteLane};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byteLane};
      F3_LH:   data_o = {{(XLEN-16){halfLane[15]}}, halfLane};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, halfLane};
      F3_LW:   data_o = wordSext;
      F3_LWU:  data_o = wordZext;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// RISC-V writeback stage: MEM/WB register, result select, variable-latency load
// wait with backpressure, register-file write port and retire counter.
module wb_stage_pipelined
  import wb_stage_pipelined_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int CNT_W      = 64,
  parameter int LD_TIMEOUT = 16,
  localparam int OFF_W     = $clog2(XLEN / 8)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m_valid_i,
  output logic             m_ready_o,
  input  logic             flush_i,
  input  logic [RA_W-1:0]  m_rd_i,
  input  logic             m_regwrite_i,
  input  logic [1:0]       m_result_sel_i,
  input  logic [XLEN-1:0]  m_alu_result_i,
  input  logic [XLEN-1:0]  m_pc_plus4_i,
  input  logic [XLEN-1:0]  m_imm_i,
  input  logic [2:0]       m_ld_funct3_i,
  input  logic [OFF_W-1:0] m_addr_lo_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             rf_we_o,
  output logic [RA_W-1:0]  rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             wb_stall_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             err_spurious_o,
  output logic             err_timeout_o
);

  localparam int TO_W = $clog2(LD_TIMEOUT + 1);

  wb_state_e        state_q, state_d;
  logic [RA_W-1:0]  rd_q;
  logic             regwrite_q;
  result_sel_e      sel_q;
  logic [XLEN-1:0]  alu_q, pc4_q, imm_q;
  logic [2:0]       funct3_q;
  logic [OFF_W-1:0] addrLo_q;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             errSpurious_q, errSpurious_d;
  logic             errTimeout_q, errTimeout_d;

  logic             held, loadPending, timeoutFire, commit, mReady, capture;
  logic [XLEN-1:0]  ldData;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= WB_EMPTY;
    else         state_q <= state_d;
  end

  // Once a commit frees the slot, a new capture refills it in the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_EMPTY:   state_d = capture ? WB_FULL : WB_EMPTY;
      WB_FULL:    state_d = commit ? (capture ? WB_FULL : WB_EMPTY) : WB_WAIT_LD;
      WB_WAIT_LD: state_d = commit ? (capture ? WB_FULL : WB_EMPTY) : WB_WAIT_LD;
      default:    state_d = WB_EMPTY;
    endcase
  end

  // Data arriving on the timeout cycle still wins: the load retires normally.
  always_comb begin
    held        = (state_q != WB_EMPTY);
    loadPending = held && (sel_q == RES_LOAD);
    timeoutFire = (state_q == WB_WAIT_LD) && (cnt_q == TO_W'(LD_TIMEOUT)) && !mem_rvalid_i;
    commit      = held && ((sel_q != RES_LOAD) || mem_rvalid_i || timeoutFire);
    mReady      = !held || commit;
    capture     = mReady && m_valid_i && !flush_i;
  end

  wb_stage_pipelined_load_align #(.XLEN(XLEN)) uLoadAlign (
    .funct3_i  (funct3_q),
    .addr_lo_i (addrLo_q),
    .rdata_i   (mem_rdata_i),
    .data_o    (ldData)
  );

  always_comb begin
    rf_wdata_o = alu_q;
    unique case (sel_q)
      RES_ALU:  rf_wdata_o = alu_q;
      RES_LOAD: rf_wdata_o = timeoutFire ? '0 : ldData;
      RES_PC4:  rf_wdata_o = pc4_q;
      RES_IMM:  rf_wdata_o = imm_q;
    endcase
  end

  assign rf_we_o        = commit && regwrite_q && (rd_q != '0);
  assign rf_waddr_o     = rd_q;
  assign m_ready_o      = mReady;
  assign wb_stall_o     = ~mReady;
  assign instret_o      = instret_q;
  assign err_spurious_o = errSpurious_q;
  assign err_timeout_o  = errTimeout_q;

  // The FULL cycle is the first wait cycle, so WAIT_LD is entered with a count of one.
  always_comb begin
    cnt_d = '0;
    if (state_q == WB_FULL && !commit)         cnt_d = TO_W'(1);
    else if (state_q == WB_WAIT_LD && !commit) cnt_d = cnt_q + TO_W'(1);
  end

  assign instret_d     = instret_q + {{(CNT_W-1){1'b0}}, commit};
  assign errSpurious_d = errSpurious_q | (mem_rvalid_i & ~loadPending);
  assign errTimeout_d  = errTimeout_q | timeoutFire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      instret_q     <= '0;
      errSpurious_q <= 1'b0;
      errTimeout_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      instret_q     <= instret_d;
      errSpurious_q <= errSpurious_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      sel_q      <= RES_ALU;
      alu_q      <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      addrLo_q   <= '0;
    end else if (capture) begin
      rd_q       <= m_rd_i;
      regwrite_q <= m_regwrite_i;
      sel_q      <= result_sel_e'(m_result_sel_i);
      alu_q      <= m_alu_result_i;
      pc4_q      <= m_pc_plus4_i;
      imm_q      <= m_imm_i;
      funct3_q   <= m_ld_funct3_i;
      addrLo_q   <= m_addr_lo_i;
    end
  end

endmodule
